alu_share_ctrl: RTL and testbench

- Time-multiplexes one shared combinational 8-bit ALU between NUM_REQ requesters.
- The ALU takes a, b and op, and returns y, parity, overflow, greater, is_eq and less.
- Each requester uses a valid/ready request channel. A single response channel returns the result tagged with the requester id.
- Arbitration is round-robin. The controller registers the operands driven into the ALU and captures its outputs one cycle later.

---
 rtl/alu_share_pkg.sv | 28 ++
 rtl/rr_arbiter.sv | 34 +++
 rtl/alu_share_ctrl.sv | 153 +++++++++++++++
 tb/tb_alu_share_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_share_pkg.sv
// Shared types and constants for the shared-ALU controller: FSM states, flag
// bit positions, op codes and the round-robin pointer helper.
package alu_share_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int FLAG_W        = 5;
    localparam int FLAG_PARITY   = 4;
    localparam int FLAG_OVERFLOW = 3;
    localparam int FLAG_GREATER  = 2;
    localparam int FLAG_IS_EQ    = 1;
    localparam int FLAG_LESS     = 0;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_AND = 2'd2;
    localparam logic [1:0] OP_XOR = 2'd3;

    // Index after id, wrapping to 0 past the last requester.
    function automatic int rr_next(input int id, input int n);
        return (id + 1 >= n) ? 0 : id + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first requester found searching
// upward from ptr_i, wrapping modulo N.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    // Scan N candidates starting at the pointer; the first hit wins.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int k = 0; k < N; k++) begin
            int               c;
            logic [IDX_W-1:0] ci;
            c  = (int'(ptr_i) + k >= N) ? (int'(ptr_i) + k - N) : (int'(ptr_i) + k);
            ci = IDX_W'(c);
            if (!valid_o && req_i[ci]) begin
                grant_o[ci] = 1'b1;
                idx_o       = ci;
                valid_o     = 1'b1;
            end else begin
                grant_o[ci] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Time-multiplexes one combinational ALU between NUM_REQ valid/ready requesters.
// Optional saturating op counter on perf_ops under macro ALU_SHARE_PERF_CNT_EN.
module alu_share_ctrl
    import alu_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*2-1:0]  req_op,
    output logic [DATA_W-1:0]     alu_a,
    output logic [DATA_W-1:0]     alu_b,
    output logic [1:0]            alu_op,
    input  logic [DATA_W-1:0]     alu_y,
    input  logic [FLAG_W-1:0]     alu_flags,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [DATA_W-1:0]     rsp_y,
    output logic [FLAG_W-1:0]     rsp_flags,
    output logic                  busy,
    output logic [15:0]           perf_ops
);

    state_e              state_q;
    logic [ID_W-1:0]     rr_ptr_q;
    logic [ID_W-1:0]     grant_id_q;
    logic [DATA_W-1:0]   alu_a_q;
    logic [DATA_W-1:0]   alu_b_q;
    logic [1:0]          alu_op_q;
    logic                rsp_valid_q;
    logic [ID_W-1:0]     rsp_id_q;
    logic [DATA_W-1:0]   rsp_y_q;
    logic [FLAG_W-1:0]   rsp_flags_q;

    logic [NUM_REQ-1:0]  grant_s;
    logic [ID_W-1:0]     pick_s;
    logic                any_s;
    logic [ID_W-1:0]     rr_next_s;
    logic                rsp_fire_s;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_arb (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant_s),
        .idx_o   (pick_s),
        .valid_o (any_s)
    );

    assign rr_next_s  = ID_W'(rr_next(int'(grant_id_q), NUM_REQ));
    assign rsp_fire_s = rsp_valid_q & rsp_ready;

    // Accept strobe is only offered while idle; the arbiter already gates it by req_valid.
    always_comb begin
        if (state_q == ST_IDLE) begin
            req_ready = grant_s;
        end else begin
            req_ready = '0;
        end
    end

    // Controller FSM with the operand and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= 2'b00;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_y_q     <= '0;
            rsp_flags_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_s) begin
                        alu_a_q    <= req_a[pick_s*DATA_W +: DATA_W];
                        alu_b_q    <= req_b[pick_s*DATA_W +: DATA_W];
                        alu_op_q   <= req_op[pick_s*2 +: 2];
                        grant_id_q <= pick_s;
                        state_q    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_y_q     <= alu_y;
                    rsp_flags_q <= alu_flags;
                    rsp_id_q    <= grant_id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_fire_s) begin
                        rsp_valid_q <= 1'b0;
                        rr_ptr_q    <= rr_next_s;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_flags = rsp_flags_q;
    assign busy      = (state_q != ST_IDLE);

`ifdef ALU_SHARE_PERF_CNT_EN
    logic [15:0] perf_q;
    logic [15:0] perf_d;

    // Count response handshakes, sticking at all-ones.
    always_comb begin
        if (rsp_fire_s && (perf_q != 16'hFFFF)) begin
            perf_d = perf_q + 16'd1;
        end else begin
            perf_d = perf_q;
        end
    end

    // Counter register, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= 16'd0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_ops = perf_q;
`else
    assign perf_ops = 16'd0;
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl: transaction-level reference model
// checked every cycle, plus directed literal checks and randomized traffic.
module tb_alu_share_ctrl;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid, req_ready;
    logic [N*W-1:0] req_a, req_b;
    logic [N*2-1:0] req_op;
    logic [W-1:0]   alu_a, alu_b, alu_y;
    logic [1:0]     alu_op;
    logic [4:0]     alu_flags;
    logic           rsp_valid, rsp_ready;
    logic [IW-1:0]  rsp_id;
    logic [W-1:0]   rsp_y;
    logic [4:0]     rsp_flags;
    logic           busy;
    logic [15:0]    perf_ops;

    logic           stub_en = 1'b0;
    logic [4:0]     stub_flags = 5'd0;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    alu_share_ctrl #(.NUM_REQ(N), .DATA_W(W), .ID_W(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_y(alu_y), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_flags(rsp_flags),
        .busy(busy), .perf_ops(perf_ops)
    );

    // Reference ALU attached to the DUT's ALU port.
    function automatic logic [7:0] f_y(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a ^ b;
        endcase
    endfunction

    function automatic logic [4:0] f_flags(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        logic [7:0] y;
        logic       ovf;
        y   = f_y(a, b, op);
        ovf = (op == 2'd0) ? ((int'(a) + int'(b)) > 255) : ((op == 2'd1) ? (a < b) : 1'b0);
        return {^y, ovf, a > b, a == b, a < b};
    endfunction

    assign alu_y     = f_y(alu_a, alu_b, alu_op);
    assign alu_flags = stub_en ? stub_flags : f_flags(alu_a, alu_b, alu_op);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model state.
    int         cyc = 0;
    bit         outst = 1'b0;
    int         acc_cyc = 0;
    int         ptr = 0;
    int         hs = 0;
    int         cur_id = 0;
    logic [7:0] cur_a, cur_b;
    logic [1:0] cur_op;
    bit         cur_stub;
    logic [4:0] cur_stub_flags;
    logic [7:0] last_a = 8'd0, last_b = 8'd0;
    logic [1:0] last_op = 2'd0;
    logic [N-1:0] exp_ready;
    bit         exp_rv;
    bit         found;
    int         gsel;
    int         exp_perf;
    int         grant_log[$];
    int         hs_cyc[$];

    // Per-cycle comparison against the model; inputs are stable at the falling edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            outst = 1'b0; ptr = 0; hs = 0;
            last_a = 8'd0; last_b = 8'd0; last_op = 2'd0;
            chk("rst_req_ready", 32'(req_ready), 32'd0);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_alu_a", 32'(alu_a), 32'd0);
            chk("rst_rsp_y", 32'(rsp_y), 32'd0);
            chk("rst_rsp_id", 32'(rsp_id), 32'd0);
            chk("rst_rsp_flags", 32'(rsp_flags), 32'd0);
            chk("rst_perf", 32'(perf_ops), 32'd0);
        end else begin
            exp_ready = '0;
            found = 1'b0;
            gsel = 0;
            if (!outst) begin
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (ptr + k) % N;
                    if (!found && req_valid[c]) begin
                        exp_ready[c] = 1'b1;
                        gsel = c;
                        found = 1'b1;
                    end
                end
            end
            exp_rv = outst && (cyc >= acc_cyc + 2);
            chk("req_ready", 32'(req_ready), 32'(exp_ready));
            chk("busy", 32'(busy), 32'(outst));
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            chk("alu_a", 32'(alu_a), 32'(last_a));
            chk("alu_b", 32'(alu_b), 32'(last_b));
            chk("alu_op", 32'(alu_op), 32'(last_op));
            if (exp_rv) begin
                chk("rsp_id", 32'(rsp_id), 32'(cur_id));
                chk("rsp_y", 32'(rsp_y), 32'(f_y(cur_a, cur_b, cur_op)));
                chk("rsp_flags", 32'(rsp_flags),
                    32'(cur_stub ? cur_stub_flags : f_flags(cur_a, cur_b, cur_op)));
            end
`ifdef ALU_SHARE_PERF_CNT_EN
            exp_perf = (hs > 65535) ? 65535 : hs;
`else
            exp_perf = 0;
`endif
            chk("perf_ops", 32'(perf_ops), 32'(exp_perf));
            if (exp_rv && rsp_ready) begin
                outst = 1'b0;
                ptr = (cur_id + 1) % N;
                hs++;
                hs_cyc.push_back(cyc);
            end
            if (found) begin
                outst = 1'b1;
                acc_cyc = cyc;
                cur_id = gsel;
                cur_a = req_a[gsel*W +: W];
                cur_b = req_b[gsel*W +: W];
                cur_op = req_op[gsel*2 +: 2];
                cur_stub = stub_en;
                cur_stub_flags = stub_flags;
                last_a = cur_a; last_b = cur_b; last_op = cur_op;
                grant_log.push_back(gsel);
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic rand_ops();
        req_a  = $urandom;
        req_b  = $urandom;
        req_op = 8'($urandom);
    endtask

    int held;
    bit seen;
    int n_before;

    initial begin
        req_valid = '0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Single request from requester 1 with a stubbed flag word.
        @(posedge clk); #1;
        req_a[1*W +: W] = 8'h05; req_b[1*W +: W] = 8'h03; req_op[1*2 +: 2] = 2'b00;
        stub_en = 1'b1; stub_flags = 5'b01000;
        req_valid = 4'b0010;
        @(negedge clk); #1;
        chk("t1_ready", 32'(req_ready), 32'h2);
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk); #1;
        chk("t1_exec_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("t1_exec_ready", 32'(req_ready), 32'd0);
        @(negedge clk); #1;
        chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t1_rsp_id", 32'(rsp_id), 32'd1);
        chk("t1_rsp_y", 32'(rsp_y), 32'h08);
        chk("t1_rsp_flags", 32'(rsp_flags), 32'b01000);
        @(posedge clk); #1 stub_en = 1'b0;

        // All requesters continuously valid after reset.
        do_reset();
        grant_log.delete(); hs_cyc.delete();
        @(posedge clk); #1 rand_ops(); req_valid = 4'b1111;
        repeat (16) begin @(posedge clk); #1 rand_ops(); end
        req_valid = '0;
        repeat (4) @(posedge clk);
        #1;
        chk("t2_grants", 32'(grant_log.size() >= 5), 32'd1);
        chk("t2_hs", 32'(hs_cyc.size() >= 5), 32'd1);
        if (grant_log.size() >= 5 && hs_cyc.size() >= 5) begin
            chk("t2_g0", 32'(grant_log[0]), 32'd0);
            chk("t2_g1", 32'(grant_log[1]), 32'd1);
            chk("t2_g2", 32'(grant_log[2]), 32'd2);
            chk("t2_g3", 32'(grant_log[3]), 32'd3);
            chk("t2_g4", 32'(grant_log[4]), 32'd0);
            for (int i = 0; i < 4; i++)
                chk("t2_interval", 32'(hs_cyc[i+1] - hs_cyc[i]), 32'd3);
        end

        // Response backpressure for 10 cycles while operands churn.
        @(posedge clk); #1 rsp_ready = 1'b0; req_valid = 4'b1111;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk); #1 seen = rsp_valid;
        end
        chk("t3_rsp_seen", 32'(seen), 32'd1);
        n_before = grant_log.size();
        held = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1 rand_ops();
            @(negedge clk); #1;
            if (rsp_valid && req_ready == '0) held++;
        end
        chk("t3_held", 32'(held), 32'd10);
        chk("t3_no_grant", 32'(grant_log.size()), 32'(n_before));
        @(posedge clk); #1 rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 req_valid = '0;
        repeat (4) @(posedge clk);

        // Pointer wrap: serve 2 only, then 3 and 0 compete.
        do_reset();
        @(posedge clk); #1 req_valid = 4'b0100;
        @(posedge clk); #1 req_valid = '0;
        repeat (4) @(posedge clk);
        #1 grant_log.delete(); req_valid = 4'b1001;
        repeat (8) @(posedge clk);
        #1 req_valid = '0;
        repeat (4) @(posedge clk);
        chk("t4_grants", 32'(grant_log.size() >= 2), 32'd1);
        if (grant_log.size() >= 2) begin
            chk("t4_g0", 32'(grant_log[0]), 32'd3);
            chk("t4_g1", 32'(grant_log[1]), 32'd0);
        end

        // Asynchronous reset while in EXEC.
        @(posedge clk); #1 req_a = 32'hA5A5A5A5; req_valid = 4'b0100;
        @(posedge clk); #2 rst_n = 1'b0; req_valid = '0;
        #1;
        chk("t5_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_alu_a", 32'(alu_a), 32'd0);
        chk("t5_rsp_y", 32'(rsp_y), 32'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1 grant_log.delete(); req_valid = 4'b1111;
        @(posedge clk); #1 req_valid = '0;
        repeat (4) @(posedge clk);
        chk("t5_grants", 32'(grant_log.size() >= 1), 32'd1);
        if (grant_log.size() >= 1) chk("t5_first", 32'(grant_log[0]), 32'd0);

        // Five completed handshakes for the performance counter.
        do_reset();
        grant_log.delete();
        @(posedge clk); #1 req_valid = 4'b1111;
        for (int i = 0; i < 50 && grant_log.size() < 5; i++) begin
            @(posedge clk); #1;
        end
        req_valid = '0;
        repeat (6) @(posedge clk);
        #1;
`ifdef ALU_SHARE_PERF_CNT_EN
        chk("t6_perf", 32'(perf_ops), 32'd5);
`else
        chk("t6_perf", 32'(perf_ops), 32'd0);
`endif

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            rand_ops();
            req_valid = 4'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        rsp_ready = 1'b1; req_valid = '0;
        repeat (5) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
